// File: rtl/isdu_pkg.sv
// isdu_pkg: state encoding, opcodes and mux-select encodings shared by the SLC-3 ISDU.
// The fetch-pause states exist only when ISDU_PAUSE_IR_EN is defined.
`default_nettype none

package isdu_pkg;

   typedef enum logic [4:0] {
      S_HALTED,
      S_FETCH_MAR,
      S_FETCH_RD,
      S_FETCH_IR,
      S_DECODE,
      S_ADD,
      S_AND,
      S_NOT,
      S_BR,
      S_BR_TAKEN,
      S_JMP,
      S_JSR,
      S_JSR_PC,
      S_JSR_R,
      S_LDR,
      S_LDR_RD,
      S_LDR_WB,
      S_STR,
      S_STR_MDR,
      S_STR_WR,
      S_PAUSE_A,
`ifdef ISDU_PAUSE_IR_EN
      S_PAUSE_B,
      S_PAUSE_IR1,
      S_PAUSE_IR2
`else
      S_PAUSE_B
`endif
   } state_t;

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [1:0] PC_PLUS1 = 2'b00;
   localparam logic [1:0] PC_BUS   = 2'b01;
   localparam logic [1:0] PC_ADDER = 2'b10;

   localparam logic [1:0] A2_ZERO  = 2'b00;
   localparam logic [1:0] A2_OFF6  = 2'b01;
   localparam logic [1:0] A2_OFF9  = 2'b10;
   localparam logic [1:0] A2_OFF11 = 2'b11;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_AND   = 2'b01;
   localparam logic [1:0] ALU_NOT   = 2'b10;
   localparam logic [1:0] ALU_PASSA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/isdu_wait_cnt.sv
// isdu_wait_cnt: SRAM wait-state counter; done flags the last cycle (count == MEM_WAIT-1).
`default_nettype none

module isdu_wait_cnt #(
   parameter int MEM_WAIT = 3,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   assign done = (count == CNT_W'(MEM_WAIT - 1));

endmodule

`default_nettype wire

// File: rtl/isdu_gen.sv
// isdu_gen: Moore-FSM instruction sequencer/decoder for the SLC-3 datapath with configurable SRAM waits.
// Define ISDU_PAUSE_IR_EN to insert a Continue handshake between FETCH_IR and DECODE.
`default_nettype none

module isdu_gen
   import isdu_pkg::*;
#(
   parameter int MEM_WAIT = 3,
   parameter int CNT_W    = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       IR_11,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic [1:0] PCMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   state_t state;
   state_t state_next;
   logic   in_wait;
   logic   wait_done;

   // Counter sits at zero outside the access states, so every access starts from zero.
   assign in_wait = (state == S_FETCH_RD) || (state == S_LDR_RD) || (state == S_STR_WR);

   isdu_wait_cnt #(
      .MEM_WAIT (MEM_WAIT),
      .CNT_W    (CNT_W)
   ) u_wait_cnt (
      .clk    (Clk),
      .rst_n  (Reset_n),
      .clear  (!in_wait),
      .enable (in_wait),
      .done   (wait_done)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state <= S_HALTED;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      PCMUX      = PC_PLUS1;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      ADDR2MUX   = A2_ZERO;
      ALUK       = ALU_ADD;
      Mem_OE     = 1'b0;
      Mem_WE     = 1'b0;

      case (state)
         S_HALTED: begin
            if (Run)
               state_next = S_FETCH_MAR;
         end
         S_FETCH_MAR: begin
            GatePC     = 1'b1;
            LD_MAR     = 1'b1;
            LD_PC      = 1'b1;
            PCMUX      = PC_PLUS1;
            state_next = S_FETCH_RD;
         end
         S_FETCH_RD: begin
            Mem_OE = 1'b1;
            if (wait_done) begin
               LD_MDR     = 1'b1;
               state_next = S_FETCH_IR;
            end
         end
         S_FETCH_IR: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
`ifdef ISDU_PAUSE_IR_EN
            state_next = S_PAUSE_IR1;
`else
            state_next = S_DECODE;
`endif
         end
`ifdef ISDU_PAUSE_IR_EN
         S_PAUSE_IR1: begin
            if (Continue)
               state_next = S_PAUSE_IR2;
         end
         S_PAUSE_IR2: begin
            if (!Continue)
               state_next = S_DECODE;
         end
`endif
         S_DECODE: begin
            LD_BEN = 1'b1;
            case (Opcode)
               OP_ADD:   state_next = S_ADD;
               OP_AND:   state_next = S_AND;
               OP_NOT:   state_next = S_NOT;
               OP_BR:    state_next = S_BR;
               OP_JMP:   state_next = S_JMP;
               OP_JSR:   state_next = S_JSR;
               OP_LDR:   state_next = S_LDR;
               OP_STR:   state_next = S_STR;
               OP_PAUSE: state_next = S_PAUSE_A;
               default:  state_next = S_FETCH_MAR;
            endcase
         end
         S_ADD, S_AND: begin
            SR1MUX     = 1'b1;
            SR2MUX     = IR_5;
            ALUK       = (state == S_AND) ? ALU_AND : ALU_ADD;
            GateALU    = 1'b1;
            LD_REG     = 1'b1;
            LD_CC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_NOT: begin
            SR1MUX     = 1'b1;
            ALUK       = ALU_NOT;
            GateALU    = 1'b1;
            LD_REG     = 1'b1;
            LD_CC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_BR: begin
            state_next = BEN ? S_BR_TAKEN : S_FETCH_MAR;
         end
         S_BR_TAKEN: begin
            ADDR2MUX   = A2_OFF9;
            PCMUX      = PC_ADDER;
            LD_PC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_JMP: begin
            SR1MUX     = 1'b1;
            ALUK       = ALU_PASSA;
            GateALU    = 1'b1;
            PCMUX      = PC_BUS;
            LD_PC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         // R7 is written before the jump, so JSRR through R7 lands on the link value.
         S_JSR: begin
            GatePC     = 1'b1;
            DRMUX      = 1'b1;
            LD_REG     = 1'b1;
            state_next = IR_11 ? S_JSR_PC : S_JSR_R;
         end
         S_JSR_PC: begin
            ADDR2MUX   = A2_OFF11;
            PCMUX      = PC_ADDER;
            LD_PC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_JSR_R: begin
            ADDR1MUX   = 1'b1;
            SR1MUX     = 1'b1;
            PCMUX      = PC_ADDER;
            LD_PC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_LDR, S_STR: begin
            SR1MUX     = 1'b1;
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = A2_OFF6;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            state_next = (state == S_LDR) ? S_LDR_RD : S_STR_MDR;
         end
         S_LDR_RD: begin
            Mem_OE = 1'b1;
            if (wait_done) begin
               LD_MDR     = 1'b1;
               state_next = S_LDR_WB;
            end
         end
         S_LDR_WB: begin
            GateMDR    = 1'b1;
            LD_REG     = 1'b1;
            LD_CC      = 1'b1;
            state_next = S_FETCH_MAR;
         end
         S_STR_MDR: begin
            ALUK       = ALU_PASSA;
            GateALU    = 1'b1;
            LD_MDR     = 1'b1;
            state_next = S_STR_WR;
         end
         S_STR_WR: begin
            Mem_WE = 1'b1;
            if (wait_done)
               state_next = S_FETCH_MAR;
         end
         S_PAUSE_A: begin
            LD_LED = 1'b1;
            if (Continue)
               state_next = S_PAUSE_B;
         end
         S_PAUSE_B: begin
            if (!Continue)
               state_next = S_FETCH_MAR;
         end
         default: state_next = S_HALTED;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_isdu_gen.sv
// tb_isdu_gen: scoreboard bench for isdu_gen (MEM_WAIT=3); one expected output vector per clock cycle.
`default_nettype none

module tb_isdu_gen;

   localparam int MW = 3;

   // Expected-vector bit layout: {loads[7:0], gates[3:0], PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE}
   localparam logic [23:0] LDMAR   = 24'h800000;
   localparam logic [23:0] LDMDR   = 24'h400000;
   localparam logic [23:0] LDIR    = 24'h200000;
   localparam logic [23:0] LDBEN   = 24'h100000;
   localparam logic [23:0] LDCC    = 24'h080000;
   localparam logic [23:0] LDREG   = 24'h040000;
   localparam logic [23:0] LDPC    = 24'h020000;
   localparam logic [23:0] LDLED   = 24'h010000;
   localparam logic [23:0] GPC     = 24'h008000;
   localparam logic [23:0] GMDR    = 24'h004000;
   localparam logic [23:0] GALU    = 24'h002000;
   localparam logic [23:0] GMAR    = 24'h001000;
   localparam logic [23:0] PCM_BUS = 24'h000400;
   localparam logic [23:0] PCM_ADR = 24'h000800;
   localparam logic [23:0] DRM     = 24'h000200;
   localparam logic [23:0] SR1     = 24'h000100;
   localparam logic [23:0] SR2     = 24'h000080;
   localparam logic [23:0] A1      = 24'h000040;
   localparam logic [23:0] A2_6    = 24'h000010;
   localparam logic [23:0] A2_9    = 24'h000020;
   localparam logic [23:0] A2_11   = 24'h000030;
   localparam logic [23:0] AK_AND  = 24'h000004;
   localparam logic [23:0] AK_NOT  = 24'h000008;
   localparam logic [23:0] AK_PA   = 24'h00000C;
   localparam logic [23:0] OE      = 24'h000002;
   localparam logic [23:0] WE      = 24'h000001;

   localparam logic [23:0] E_FMAR = GPC | LDMAR | LDPC;
   localparam logic [23:0] E_FIR  = GMDR | LDIR;
   localparam logic [23:0] E_ALU  = SR1 | GALU | LDREG | LDCC;
   localparam logic [23:0] E_ADDR = SR1 | A1 | A2_6 | GMAR | LDMAR;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Run = 1'b0;
   logic       Continue = 1'b0;
   logic [3:0] Opcode = 4'h0;
   logic       IR_5 = 1'b0;
   logic       IR_11 = 1'b0;
   logic       BEN = 1'b0;
   logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

   isdu_gen #(.MEM_WAIT(MW), .CNT_W(4)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
      .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   always #5 Clk = ~Clk;

   logic [23:0] outs;
   assign outs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                  ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

   typedef struct {
      logic [23:0] v;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Monitor: the DUT presents a Moore output vector every cycle; compare mid-cycle.
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (outs !== e.v) begin
            errors++;
            $display("FAIL %s @%0t: outputs got=%06h exp=%06h", e.tag, $time, outs, e.v);
         end
         checks++;
         if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
            errors++;
            $display("FAIL bus_gates %s @%0t: gates got=%b exp=at most one high", e.tag, $time,
                     {GatePC, GateMDR, GateALU, GateMARMUX});
         end
      end
   end

   // Push the expectation for the current cycle, then advance to just after the next edge.
   task automatic cyc(input logic [23:0] v, input string tag);
      exp_t e;
      e.v = v;
      e.tag = tag;
      sb.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic fetch();
      cyc(E_FMAR, "fetch_mar");
      for (int i = 0; i < MW; i++)
         cyc((i == MW - 1) ? (OE | LDMDR) : OE, "fetch_rd");
      cyc(E_FIR, "fetch_ir");
   endtask

   task automatic decode(input logic [3:0] op, input logic i5, input logic i11, input logic ben);
      Opcode = op;
      IR_5   = i5;
      IR_11  = i11;
      BEN    = ben;
      cyc(LDBEN, "decode");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      @(posedge Clk);
      #1;
      cyc(24'h0, "reset_state");
      Reset_n = 1'b1;
      cyc(24'h0, "halted_no_run");
      Run = 1'b1;
      cyc(24'h0, "halted_run");

      // ADD imm, with Run held high to show it is ignored outside HALTED
      fetch();
      decode(4'b0001, 1'b1, 1'b0, 1'b0);
      cyc(E_ALU | SR2, "add_imm");
      Run = 1'b0;

      fetch();
      decode(4'b0101, 1'b0, 1'b0, 1'b0);
      cyc(E_ALU | AK_AND, "and_reg");

      fetch();
      decode(4'b1001, 1'b0, 1'b0, 1'b0);
      cyc(E_ALU | AK_NOT, "not");

      fetch();
      decode(4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(24'h0, "br_not_taken");

      fetch();
      decode(4'b0000, 1'b0, 1'b0, 1'b1);
      cyc(24'h0, "br");
      cyc(A2_9 | PCM_ADR | LDPC, "br_taken");

      fetch();
      decode(4'b1100, 1'b0, 1'b0, 1'b0);
      cyc(SR1 | AK_PA | GALU | PCM_BUS | LDPC, "jmp");

      fetch();
      decode(4'b0100, 1'b0, 1'b1, 1'b0);
      cyc(GPC | DRM | LDREG, "jsr_link");
      cyc(A2_11 | PCM_ADR | LDPC, "jsr_pc");

      fetch();
      decode(4'b0100, 1'b0, 1'b0, 1'b0);
      cyc(GPC | DRM | LDREG, "jsrr_link");
      cyc(A1 | SR1 | PCM_ADR | LDPC, "jsrr");

      fetch();
      decode(4'b0110, 1'b0, 1'b0, 1'b0);
      cyc(E_ADDR, "ldr_addr");
      for (int i = 0; i < MW; i++)
         cyc((i == MW - 1) ? (OE | LDMDR) : OE, "ldr_rd");
      cyc(GMDR | LDREG | LDCC, "ldr_wb");

      fetch();
      decode(4'b0111, 1'b0, 1'b0, 1'b0);
      cyc(E_ADDR, "str_addr");
      cyc(AK_PA | GALU | LDMDR, "str_mdr");
      for (int i = 0; i < MW; i++)
         cyc(WE, "str_wr");

      fetch();
      decode(4'b1101, 1'b0, 1'b0, 1'b0);
      Continue = 1'b0;
      cyc(LDLED, "pause_a_wait");
      cyc(LDLED, "pause_a_wait");
      Continue = 1'b1;
      cyc(LDLED, "pause_a_go");
      cyc(24'h0, "pause_b_hold");
      Continue = 1'b0;
      cyc(24'h0, "pause_b_go");

      fetch();
      decode(4'b1111, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of an LDR read
      fetch();
      decode(4'b0110, 1'b0, 1'b0, 1'b0);
      cyc(E_ADDR, "ldr_addr2");
      cyc(OE, "ldr_rd_first");
      Reset_n = 1'b0;
      cyc(24'h0, "reset_mid_ldr");
      cyc(24'h0, "reset_hold");
      Reset_n = 1'b1;
      Run = 1'b1;
      cyc(24'h0, "reset_release_run");
      Run = 1'b0;
      cyc(E_FMAR, "fetch_after_reset");

      for (int k = 0; k < 4 && sb.size() > 0; k++)
         @(negedge Clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: pending got=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
